// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_frame_ctrl
// Description : UART receive frame controller. Walks a frame through
//               START / DATA / PARITY / STOP using an external edge/bit
//               counter, samples each bit near its centre, checks parity
//               and stop bit, and presents good bytes with a one-cycle
//               strobe.
//               Build option UART_RX_MAJORITY_EN: when defined, each bit is
//               a 3-sample majority vote around the bit centre; otherwise a
//               single centre sample is used.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frame_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  input  logic [5:0] Prescale,
  input  logic [4:0] edge_cnt,
  input  logic [3:0] bit_cnt,
  output logic       cnt_enable,
  output logic [7:0] P_DATA,
  output logic       data_valid,
  output logic       par_err,
  output logic       stp_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic       r_par_en;
  logic       r_par_typ;
  logic [7:0] r_shift;
  logic [2:0] r_data_idx;   // data EOBs seen so far; backs up bit_cnt for exit
  logic       r_sampled;

  logic [5:0] w_edge;
  logic [5:0] w_half;
  logic [5:0] w_last;
  logic       w_eob;
  logic       w_data_last;
  logic       w_exp_par;
  logic [2:0] w_bit_idx;
  logic       w_bit_ok;

  assign w_edge = {1'b0, edge_cnt};
  assign w_half = {1'b0, Prescale[5:1]};
  // Out-of-range prescales fall back to the 5-bit counter ceiling so EOB
  // always arrives and the FSM cannot stall.
  assign w_last = ((Prescale == 6'd0) || (Prescale > 6'd32)) ? 6'd31 : (Prescale - 6'd1);
  assign w_eob  = (r_state != S_IDLE) && (w_edge >= w_last);

  // Leave DATA on the 8th data bit, even if the counter misreports bit_cnt.
  assign w_data_last = (bit_cnt >= 4'd8) || (r_data_idx == 3'd7);
  assign w_exp_par   = (^r_shift) ^ r_par_typ;
  // bit_cnt 1..8 maps to shift bit 0..7 (bit_cnt 8 wraps to 0-1 = 7).
  assign w_bit_idx   = bit_cnt[2:0] - 3'd1;
  assign w_bit_ok    = (bit_cnt >= 4'd1) && (bit_cnt <= 4'd8);

`ifdef UART_RX_MAJORITY_EN
  logic r_s0;
  logic r_s1;

  // Capture the two early samples that precede the majority decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
    end else if (r_state != S_IDLE) begin
      if (w_edge == (w_half - 6'd1)) r_s0 <= RX_IN;
      if (w_edge == w_half)          r_s1 <= RX_IN;
    end
  end

  // Register the majority of the three samples on the third sample point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sampled <= 1'b0;
    end else if ((r_state != S_IDLE) && (w_edge == (w_half + 6'd1))) begin
      r_sampled <= (r_s0 & r_s1) | (r_s0 & RX_IN) | (r_s1 & RX_IN);
    end
  end
`else
  // Register a single sample taken at the bit centre.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sampled <= 1'b0;
    end else if ((r_state != S_IDLE) && (w_edge == w_half)) begin
      r_sampled <= RX_IN;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode and counter enable.
  always_comb begin
    w_next     = r_state;
    cnt_enable = 1'b1;
    case (r_state)
      S_IDLE: begin
        cnt_enable = 1'b0;
        if (!RX_IN) w_next = S_START;
      end
      S_START: begin
        if (w_eob) w_next = r_sampled ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_eob && w_data_last) w_next = r_par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_eob) w_next = S_STOP;
      end
      S_STOP: begin
        if (w_eob) w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Frame datapath: config latch, shift register, error flags and output byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_shift    <= 8'h00;
      r_data_idx <= 3'd0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      P_DATA     <= 8'h00;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!RX_IN) begin
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_data_idx <= 3'd0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
          end
        end
        S_DATA: begin
          if (w_eob) begin
            if (w_bit_ok) r_shift[w_bit_idx] <= r_sampled;
            r_data_idx <= r_data_idx + 3'd1;
          end
        end
        S_PARITY: begin
          if (w_eob) par_err <= (r_sampled != w_exp_par);
        end
        S_STOP: begin
          if (w_eob) begin
            stp_err <= ~r_sampled;
            if (!par_err && r_sampled) begin
              P_DATA     <= r_shift;
              data_valid <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
